// File: rtl/load_store_unit.sv
// Load/store unit: RV32I byte/half/word loads and stores on a word-only data memory.
// Handles alignment/range checks, lane extraction with extension, and read-modify-write.
`timescale 1ns/1ps
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        STORE,
        RESP
    } state_t;

    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS) << 2;

    state_t                state;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  error_q;

    logic                  legal_f3;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  req_bad;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           load_ext;
    logic [31:0]           merged;

    // Classify the incoming request so illegal ones never touch memory.
    always_comb begin
        if (req_write) begin
            legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010);
        end else begin
            legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                       (req_funct3 == 3'b101);
        end
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = ({1'b0, req_addr} >= LIMIT);
        req_bad = !legal_f3 || misaligned || out_of_range;
    end

    // Pick the addressed lane out of the read word and extend it for the load result.
    always_comb begin
        byte_sel = 8'h00;
        unique case (addr_q[1:0])
            2'b00: byte_sel = mem_read_data[7:0];
            2'b01: byte_sel = mem_read_data[15:8];
            2'b10: byte_sel = mem_read_data[23:16];
            2'b11: byte_sel = mem_read_data[31:24];
        endcase
        half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        unique case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = mem_read_data;
        endcase
    end

    // Splice the store byte/half into the word read back for SB/SH.
    always_comb begin
        merged = mem_read_data;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Control FSM and request/response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            error_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rdata_q  <= 32'h0;
                        error_q  <= req_bad;
                        if (req_bad) begin
                            state <= RESP;
                        end else if (!req_write) begin
                            state <= LOAD;
                        end else if (req_funct3[1:0] == 2'b10) begin
                            state <= STORE;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    rdata_q <= load_ext;
                    state   <= RESP;
                end
                RMW_RD: begin
                    wdata_q <= merged;
                    state   <= STORE;
                end
                STORE: begin
                    state <= RESP;
                end
                RESP: begin
                    rdata_q <= 32'h0;
                    error_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore decode: memory strobes and response fields follow the state alone.
    always_comb begin
        req_ready      = (state == IDLE) && !reset;
        mem_read       = (state == LOAD) || (state == RMW_RD);
        mem_write      = (state == STORE);
        mem_address    = '0;
        mem_write_data = 32'h0;
        if (mem_read || mem_write) begin
            mem_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        end
        if (mem_write) begin
            mem_write_data = wdata_q;
        end
        resp_valid = (state == RESP);
        resp_rdata = resp_valid ? rdata_q : 32'h0;
        resp_error = resp_valid && error_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: word memory model plus a byte-level
// reference model of RV32I load/store semantics.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] dmem [0:1023];
    bit          init_done;
    logic [7:0]  rb [0:4095];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .MEM_WORDS(1024)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    assign mem_read_data = dmem[mem_address[11:2]];

    // Data memory: filled once, then written on edges where mem_write is high.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= init_word(i);
            init_done <= 1'b1;
        end else if (mem_write && mem_address < 32'd4096) begin
            dmem[mem_address[11:2]] <= mem_write_data;
        end
    end

    // Reference: byte-addressed memory, sizes and extension from the ISA rules.
    task automatic model_op(input logic w, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] er, output logic ee,
                            output int el, output int enr, output int enw);
        int size;
        logic sgn, legal;
        logic [31:0] v;
        legal = 1'b1; sgn = 1'b0; size = 1;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: legal = 1'b0;
        endcase
        if (w && f3 > 3'd2) legal = 1'b0;
        ee = !legal || ((a % 32'(size)) != 0) || (a >= 32'd4096);
        er = 32'h0; el = 0; enr = 0; enw = 0;
        if (!ee) begin
            if (!w) begin
                v = 32'h0;
                for (int k = 0; k < size; k++)
                    v = v | (32'(rb[int'(a) + k]) << (8 * k));
                if (sgn && size < 4 && v[8*size-1])
                    v = v | ~((32'h1 << (8 * size)) - 32'h1);
                er = v; el = 1; enr = 1;
            end else begin
                for (int k = 0; k < size; k++)
                    rb[int'(a) + k] = 8'(wd >> (8 * k));
                el = (size == 4) ? 1 : 2;
                enr = (size == 4) ? 0 : 1;
                enw = 1;
            end
        end
    endtask

    // Drive one request and observe its response and memory activity.
    task automatic run_req(input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er,
                           output int lat, output int nr, output int nw,
                           output int stray, output logic after_ok);
        int i;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        i = 0;
        while (!req_ready && i < 20) begin @(negedge clk); i++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; nr = 0; nw = 0; stray = 0;
        while (!resp_valid && lat < 10) begin
            nr += int'(mem_read); nw += int'(mem_write);
            if (resp_rdata !== 32'h0 || resp_error !== 1'b0) stray++;
            if ((mem_read || mem_write) && mem_address !== {a[31:2], 2'b00}) stray++;
            @(posedge clk); #1; lat++;
        end
        nr += int'(mem_read); nw += int'(mem_write);
        checks++;
        if (!resp_valid) begin
            errors++;
            $display("FAIL response_timeout: got no resp_valid, required within 10 cycles");
        end
        rd = resp_rdata; er = resp_error;
        @(posedge clk); #1;
        after_ok = !resp_valid && req_ready;
    endtask

    task automatic check_mem(input string tag);
        int bad;
        logic [31:0] wv;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            wv = {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]};
            if (dmem[i] !== wv) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL mem_%s: %0d words differ from reference, required 0", tag, bad);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_error, mem_read, mem_write} !== 5'b0 ||
            resp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rv=%b mr=%b mw=%b addr=%h, required all 0",
                     req_ready, resp_valid, mem_read, mem_write, mem_address);
        end
        @(negedge clk); reset = 1'b0; #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b rv=%b mr=%b mw=%b, required 1 0 0 0",
                     req_ready, resp_valid, mem_read, mem_write);
        end
    endtask

    typedef struct packed {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } op_t;

    task automatic test_directed();
        op_t tbl [11] = '{
            '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF},
            '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF},
            '{1'b1, 3'd2, 32'h10, 32'h80FF7F01, 32'h80FF7F01},
            '{1'b0, 3'd0, 32'h13, 32'h0,        32'hFFFFFF80},
            '{1'b0, 3'd4, 32'h13, 32'h0,        32'h00000080},
            '{1'b0, 3'd1, 32'h12, 32'h0,        32'hFFFF80FF},
            '{1'b0, 3'd5, 32'h10, 32'h0,        32'h00007F01},
            '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF},
            '{1'b1, 3'd0, 32'h11, 32'h00000012, 32'hDEAD12EF},
            '{1'b1, 3'd1, 32'h12, 32'h0000A5A5, 32'hA5A512EF},
            '{1'b0, 3'd2, 32'h10, 32'h0,        32'hA5A512EF}
        };
        logic [31:0] rd, erd, got;
        logic er, eer, after_ok;
        int lat, nr, nw, stray, el, enr, enw;
        for (int i = 0; i < 11; i++) begin
            model_op(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, erd, eer, el, enr, enw);
            run_req(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, rd, er, lat, nr, nw, stray, after_ok);
            got = tbl[i].w ? dmem[4] : rd;
            checks++;
            if (got !== tbl[i].exp || er !== 1'b0 || (tbl[i].w && rd !== 32'h0)) begin
                errors++;
                $display("FAIL directed_%0d: value=%h err=%b rdata=%h, required value=%h err=0",
                         i, got, er, rd, tbl[i].exp);
            end
            checks++;
            if (lat !== el || nr !== enr || nw !== enw || stray !== 0 || !after_ok) begin
                errors++;
                $display("FAIL directed_timing_%0d: lat=%0d rd=%0d wr=%0d stray=%0d next_ok=%b, required lat=%0d rd=%0d wr=%0d stray=0 next_ok=1",
                         i, lat, nr, nw, stray, after_ok, el, enr, enw);
            end
        end
        check_mem("directed");
    endtask

    task automatic test_errors();
        logic [36:0] tbl [10] = '{
            {1'b0, 3'd2, 32'h00000012, 1'b1},
            {1'b1, 3'd1, 32'h00000011, 1'b1},
            {1'b0, 3'd3, 32'h00000010, 1'b1},
            {1'b0, 3'd2, 32'h00001000, 1'b1},
            {1'b1, 3'd4, 32'h00000010, 1'b1},
            {1'b0, 3'd6, 32'h00000010, 1'b1},
            {1'b0, 3'd0, 32'h00001000, 1'b1},
            {1'b0, 3'd0, 32'h00000FFF, 1'b0},
            {1'b0, 3'd2, 32'h00000FFC, 1'b0},
            {1'b1, 3'd1, 32'h00000FFE, 1'b0}
        };
        logic w, er, eer, after_ok, xerr;
        logic [2:0] f3;
        logic [31:0] a, wd, rd, erd;
        int lat, nr, nw, stray, el, enr, enw;
        for (int i = 0; i < 10; i++) begin
            {w, f3, a, xerr} = tbl[i];
            wd = $urandom;
            model_op(w, f3, a, wd, erd, eer, el, enr, enw);
            run_req(w, f3, a, wd, rd, er, lat, nr, nw, stray, after_ok);
            checks++;
            if (er !== xerr || rd !== erd) begin
                errors++;
                $display("FAIL error_case_%0d: err=%b rdata=%h, required err=%b rdata=%h",
                         i, er, rd, xerr, erd);
            end
            checks++;
            if (lat !== el || nr !== enr || nw !== enw || stray !== 0 || !after_ok) begin
                errors++;
                $display("FAIL error_timing_%0d: lat=%0d rd=%0d wr=%0d stray=%0d next_ok=%b, required lat=%0d rd=%0d wr=%0d stray=0 next_ok=1",
                         i, lat, nr, nw, stray, after_ok, el, enr, enw);
            end
        end
        check_mem("errors");
    endtask

    task automatic test_random();
        logic w, er, eer, after_ok;
        logic [2:0] f3;
        logic [31:0] a, wd, rd, erd;
        int lat, nr, nw, stray, el, enr, enw, r;
        for (int i = 0; i < 150; i++) begin
            w = 1'($urandom); f3 = 3'($urandom); wd = $urandom;
            r = $urandom_range(0, 9);
            if (r < 7) a = $urandom_range(0, 63);
            else if (r < 9) a = $urandom_range(32'hFF0, 32'h100F);
            else a = $urandom;
            model_op(w, f3, a, wd, erd, eer, el, enr, enw);
            run_req(w, f3, a, wd, rd, er, lat, nr, nw, stray, after_ok);
            checks++;
            if (rd !== erd || er !== eer) begin
                errors++;
                $display("FAIL random_%0d: w=%b f3=%0d a=%h rdata=%h err=%b, required rdata=%h err=%b",
                         i, w, f3, a, rd, er, erd, eer);
            end
            checks++;
            if (lat !== el || nr !== enr || nw !== enw || stray !== 0 || !after_ok) begin
                errors++;
                $display("FAIL random_timing_%0d: lat=%0d rd=%0d wr=%0d stray=%0d next_ok=%b, required lat=%0d rd=%0d wr=%0d stray=0 next_ok=1",
                         i, lat, nr, nw, stray, after_ok, el, enr, enw);
            end
        end
        check_mem("random");
    endtask

    task automatic test_back_to_back();
        localparam int N = 14;
        logic        ws [N];
        logic [2:0]  fs [N];
        logic [31:0] as [N];
        logic [31:0] ds [N];
        logic [32:0] expq [$];
        logic [32:0] e;
        logic [31:0] erd;
        logic eer, ready_at;
        int k, acc, resps, cycles, viol, bad, el, enr, enw;
        for (int i = 0; i < N; i++) begin
            ws[i] = 1'($urandom);
            fs[i] = 3'($urandom_range(0, 5));
            as[i] = ($urandom_range(0, 9) == 0) ? 32'h2000 : 32'($urandom_range(0, 31));
            ds[i] = $urandom;
        end
        k = 0; acc = 0; resps = 0; cycles = 0; viol = 0; bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = ws[0]; req_funct3 = fs[0];
        req_addr = as[0]; req_wdata = ds[0];
        while ((acc < N || resps < acc) && cycles < 300) begin
            ready_at = req_ready;
            @(posedge clk); #1; cycles++;
            if (ready_at && req_valid) begin
                model_op(ws[k], fs[k], as[k], ds[k], erd, eer, el, enr, enw);
                expq.push_back({eer, erd});
                acc++; k++;
                if (k < N) begin
                    req_write = ws[k]; req_funct3 = fs[k];
                    req_addr = as[k]; req_wdata = ds[k];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (acc > resps && req_ready !== 1'b0) viol++;
            if (resp_valid) begin
                if (expq.size() == 0) bad++;
                else begin
                    e = expq.pop_front();
                    if ({resp_error, resp_rdata} !== e) bad++;
                end
                resps++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++;
        if (acc !== N || resps !== N) begin
            errors++;
            $display("FAIL b2b_count: accepted=%0d responses=%0d, required %0d each", acc, resps, N);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b_data: %0d responses differ from reference, required 0", bad);
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL b2b_ready: ready high in %0d busy cycles, required 0", viol);
        end
        check_mem("b2b");
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] old;
        int i, nresp;
        old = dmem[8];
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h20; req_wdata = ~old;
        i = 0;
        while (!req_ready && i < 20) begin @(negedge clk); i++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL mid_store_state: mem_write=%b, required 1", mem_write);
        end
        reset = 1'b1; #1;
        checks++;
        if (mem_write !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_store_abort: mem_write=%b ready=%b, required 0 0", mem_write, req_ready);
        end
        @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_store_release: ready=%b, required 1", req_ready);
        end
        nresp = 0;
        repeat (4) begin
            if (resp_valid) nresp++;
            @(posedge clk); #1;
        end
        checks++;
        if (nresp !== 0 || dmem[8] !== old) begin
            errors++;
            $display("FAIL mid_store_effect: responses=%0d word8=%h, required 0 and %h",
                     nresp, dmem[8], old);
        end
        check_mem("reset_mid_store");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]} = init_word(i);
        end
        test_reset();
        test_directed();
        test_errors();
        test_random();
        test_back_to_back();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
